// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (CPU = port 0, DMA = port 1) with lock ownership and lock timeout.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise port 0 wins contention.
module dmem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [2:0]  p0_memop,
   input  logic        p0_we,
   input  logic        p0_lock,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [2:0]  p1_memop,
   input  logic        p1_we,
   input  logic        p1_lock,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   output logic [2:0]  mem_memop,
   output logic        mem_we,
   input  logic [31:0] mem_dataout,
   output logic [1:0]  dbg_state
);

   // Handshake: an access is issued in the cycle where pN_req and pN_gnt are both 1;
   // its completion (pN_rvalid with pN_err/pN_rdata) appears exactly one cycle later.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  lock_cnt_q, lock_cnt_d;
   logic        tag_valid_q, tag_port_q, tag_err_q, tag_we_q;
   logic        gnt0, gnt1;
   logic        p0_illegal, p1_illegal;
   logic        favour1;
   logic        done_live;

   function automatic logic is_illegal(input logic [2:0] memop, input logic [1:0] a);
      is_illegal = (memop == 3'b011) || (memop == 3'b110) || (memop == 3'b111) ||
                   ((memop[1:0] == 2'b10) && (a != 2'b00)) ||
                   ((memop[1:0] == 2'b01) && a[0]);
   endfunction

   assign p0_illegal = is_illegal(p0_memop, p0_addr[1:0]);
   assign p1_illegal = is_illegal(p1_memop, p1_addr[1:0]);

`ifdef DMEM_ARB_RR_EN
   logic rr_ptr_q;
   // Pointer names the port favoured at the next IDLE contention.
   always_ff @(posedge clk) begin
      if (rst)       rr_ptr_q <= 1'b0;
      else if (gnt0) rr_ptr_q <= 1'b1;
      else if (gnt1) rr_ptr_q <= 1'b0;
   end
   assign favour1 = rr_ptr_q;
`else
   assign favour1 = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      case (state_q)
         IDLE: begin
            if (p0_req && p1_req) begin
               gnt0 = !favour1;
               gnt1 = favour1;
            end else begin
               gnt0 = p0_req;
               gnt1 = p1_req;
            end
         end
         LOCK0:   gnt0 = p0_req;
         LOCK1:   gnt1 = p1_req;
         default: ;
      endcase
      if (rst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
      if (gnt0) begin
         state_d    = p0_lock ? LOCK0 : IDLE;
         lock_cnt_d = 4'd0;
      end else if (gnt1) begin
         state_d    = p1_lock ? LOCK1 : IDLE;
         lock_cnt_d = 4'd0;
      end else if (state_q != IDLE) begin
         // The owner's 15th idle locked cycle releases the lock.
         if (lock_cnt_q == 4'd14) begin
            state_d    = IDLE;
            lock_cnt_d = 4'd0;
         end else begin
            lock_cnt_d = lock_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lock_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   always_comb begin
      mem_addr   = 32'd0;
      mem_datain = 32'd0;
      mem_memop  = 3'b010;
      mem_we     = 1'b0;
      if (gnt0) begin
         mem_addr   = p0_addr;
         mem_datain = p0_wdata;
         mem_memop  = p0_memop;
         mem_we     = p0_we && !p0_illegal;
      end else if (gnt1) begin
         mem_addr   = p1_addr;
         mem_datain = p1_wdata;
         mem_memop  = p1_memop;
         mem_we     = p1_we && !p1_illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid_q <= 1'b0;
         tag_port_q  <= 1'b0;
         tag_err_q   <= 1'b0;
         tag_we_q    <= 1'b0;
      end else begin
         tag_valid_q <= gnt0 || gnt1;
         tag_port_q  <= gnt1;
         tag_err_q   <= gnt1 ? p1_illegal : p0_illegal;
         tag_we_q    <= gnt1 ? p1_we : p0_we;
      end
   end

   // A reset cycle also suppresses the completion of the access granted just before it.
   assign done_live = tag_valid_q && !rst;

   assign p0_gnt    = gnt0;
   assign p1_gnt    = gnt1;
   assign p0_rvalid = done_live && !tag_port_q;
   assign p1_rvalid = done_live && tag_port_q;
   assign p0_err    = p0_rvalid && tag_err_q;
   assign p1_err    = p1_rvalid && tag_err_q;
   assign p0_rdata  = (p0_rvalid && !tag_err_q && !tag_we_q) ? mem_dataout : 32'd0;
   assign p1_rdata  = (p1_rvalid && !tag_err_q && !tag_we_q) ? mem_dataout : 32'd0;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_req = 0, p1_req = 0;
   logic [31:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
   logic [2:0]  p0_memop = 3'b010, p1_memop = 3'b010;
   logic        p0_we = 0, p1_we = 0, p0_lock = 0, p1_lock = 0;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] mem_addr, mem_datain;
   logic [2:0]  mem_memop;
   logic        mem_we;
   logic [31:0] mem_dataout = 32'd0;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_memop(p0_memop),
      .p0_we(p0_we), .p0_lock(p0_lock), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
      .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_memop(p1_memop),
      .p1_we(p1_we), .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
      .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_memop(mem_memop), .mem_we(mem_we),
      .mem_dataout(mem_dataout), .dbg_state(dbg_state)
   );

   // clock / memory model
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      mem_fn = {~a[15:0], a[15:0]};
   endfunction

   always @(posedge clk) mem_dataout <= mem_fn(mem_addr);

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0; p0_lock = 0; p1_lock = 0;
      p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
      p0_memop = 3'b010; p1_memop = 3'b010;
   endtask

   task automatic drive(input int p, input logic req, input logic [31:0] addr,
                        input logic [2:0] memop, input logic we, input logic lock,
                        input logic [31:0] wdata);
      if (p == 0) begin
         p0_req = req; p0_addr = addr; p0_memop = memop; p0_we = we; p0_lock = lock; p0_wdata = wdata;
      end else begin
         p1_req = req; p1_addr = addr; p1_memop = memop; p1_we = we; p1_lock = lock; p1_wdata = wdata;
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      drive(0, 1, 32'h10, 3'b010, 1, 1, 32'h1234);
      drive(1, 1, 32'h20, 3'b010, 1, 0, 32'h5678);
      @(negedge clk);
      checks++;
      if ({p0_gnt, p1_gnt, mem_we} !== 3'b000) begin
         failures++;
         $display("FAIL reset_gnt got=%b exp=000", {p0_gnt, p1_gnt, mem_we});
      end
      tick();
      rst = 0;
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0000 || p0_rdata !== 0 || p1_rdata !== 0) begin
         failures++;
         $display("FAIL reset_outputs got rv=%b%b err=%b%b exp zeros", p0_rvalid, p1_rvalid, p0_err, p1_err);
      end
      checks++;
      if (mem_addr !== 0 || mem_datain !== 0 || mem_memop !== 3'b010 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_mem got addr=%h op=%b st=%0d exp 0/010/0", mem_addr, mem_memop, dbg_state);
      end
      tick();
   endtask

   task automatic test_contention();
      do_reset();
      drive(0, 1, 32'h10, 3'b010, 0, 0, 0);
      drive(1, 1, 32'h20, 3'b010, 0, 0, 0);
      @(negedge clk);
      checks++;
      if ({p0_gnt, p1_gnt} !== 2'b10 || mem_addr !== 32'h10) begin
         failures++;
         $display("FAIL cont_c1 got gnt=%b addr=%h exp gnt=10 addr=10", {p0_gnt, p1_gnt}, mem_addr);
      end
      tick();
      @(negedge clk);
      checks++;
`ifdef DMEM_ARB_RR_EN
      if ({p0_gnt, p1_gnt} !== 2'b01 || mem_addr !== 32'h20) begin
         failures++;
         $display("FAIL cont_c2 got gnt=%b addr=%h exp gnt=01 addr=20", {p0_gnt, p1_gnt}, mem_addr);
      end
`else
      if ({p0_gnt, p1_gnt} !== 2'b10 || mem_addr !== 32'h10) begin
         failures++;
         $display("FAIL cont_c2 got gnt=%b addr=%h exp gnt=10 addr=10", {p0_gnt, p1_gnt}, mem_addr);
      end
`endif
      checks++;
      if (p0_rvalid !== 1 || p1_rvalid !== 0 || p0_rdata !== mem_fn(32'h10)) begin
         failures++;
         $display("FAIL cont_c2_rd got rv=%b%b rdata=%h exp rv=10 rdata=%h", p0_rvalid, p1_rvalid, p0_rdata, mem_fn(32'h10));
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
`ifdef DMEM_ARB_RR_EN
      if (p1_rvalid !== 1 || p0_rvalid !== 0 || p1_rdata !== mem_fn(32'h20)) begin
         failures++;
         $display("FAIL cont_c3_rd got rv=%b%b rdata=%h exp rv=01 rdata=%h", p0_rvalid, p1_rvalid, p1_rdata, mem_fn(32'h20));
      end
`else
      if (p0_rvalid !== 1 || p1_rvalid !== 0 || p0_rdata !== mem_fn(32'h10)) begin
         failures++;
         $display("FAIL cont_c3_rd got rv=%b%b rdata=%h exp rv=10 rdata=%h", p0_rvalid, p1_rvalid, p0_rdata, mem_fn(32'h10));
      end
`endif
      tick();
   endtask

   task automatic test_lock();
      do_reset();
      drive(1, 1, 32'h40, 3'b010, 1, 1, 32'hDEADBEEF);
      @(negedge clk);
      checks++;
      if (p1_gnt !== 1 || mem_we !== 1 || mem_addr !== 32'h40 || mem_datain !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL lock_store got gnt=%b we=%b addr=%h din=%h exp 1/1/40/deadbeef", p1_gnt, mem_we, mem_addr, mem_datain);
      end
      tick();
      drive(1, 0, 0, 3'b010, 0, 0, 0);
      drive(0, 1, 32'h10, 3'b010, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (p0_gnt !== 0 || dbg_state !== 2'd2) begin
            failures++;
            $display("FAIL lock_hold[%0d] got p0_gnt=%b st=%0d exp 0/2", i, p0_gnt, dbg_state);
         end
         if (i == 0) begin
            checks++;
            if (p1_rvalid !== 1 || p1_err !== 0 || p1_rdata !== 0) begin
               failures++;
               $display("FAIL lock_store_done got rv=%b err=%b rdata=%h exp 1/0/0", p1_rvalid, p1_err, p1_rdata);
            end
         end
         tick();
      end
      drive(1, 1, 32'h44, 3'b010, 1, 0, 32'h1);
      @(negedge clk);
      checks++;
      if ({p0_gnt, p1_gnt} !== 2'b01) begin
         failures++;
         $display("FAIL lock_release got gnt=%b exp 01", {p0_gnt, p1_gnt});
      end
      tick();
      drive(1, 0, 0, 3'b010, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (p0_gnt !== 1 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL lock_after got p0_gnt=%b st=%0d exp 1/0", p0_gnt, dbg_state);
      end
      tick();
   endtask

   task automatic test_misaligned();
      logic [2:0]  ops [3];
      logic [31:0] adr [3];
      logic        wes [3];
      ops[0] = 3'b010; adr[0] = 32'h13; wes[0] = 0;
      ops[1] = 3'b001; adr[1] = 32'h21; wes[1] = 1;
      ops[2] = 3'b011; adr[2] = 32'h30; wes[2] = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(0, 1, adr[i], ops[i], wes[i], 0, 32'hFFFF_FFFF);
         else idle_inputs();
         @(negedge clk);
         if (i < 3) begin
            checks++;
            if (p0_gnt !== 1 || mem_we !== 0) begin
               failures++;
               $display("FAIL misalign_issue[%0d] got gnt=%b we=%b exp 1/0", i, p0_gnt, mem_we);
            end
         end
         if (i > 0) begin
            checks++;
            if (p0_rvalid !== 1 || p0_err !== 1 || p0_rdata !== 0) begin
               failures++;
               $display("FAIL misalign_done[%0d] got rv=%b err=%b rdata=%h exp 1/1/0", i - 1, p0_rvalid, p0_err, p0_rdata);
            end
         end
         tick();
      end
   endtask

   task automatic test_timeout();
      do_reset();
      drive(0, 1, 32'h10, 3'b010, 0, 1, 0);
      @(negedge clk);
      checks++;
      if (p0_gnt !== 1) begin
         failures++;
         $display("FAIL timeout_lock got p0_gnt=%b exp 1", p0_gnt);
      end
      tick();
      drive(0, 0, 0, 3'b010, 0, 0, 0);
      drive(1, 1, 32'h20, 3'b010, 0, 0, 0);
      for (int c = 2; c <= 17; c++) begin
         @(negedge clk);
         checks++;
         if (c < 17 && (p1_gnt !== 0 || dbg_state !== 2'd1)) begin
            failures++;
            $display("FAIL timeout_hold[c%0d] got p1_gnt=%b st=%0d exp 0/1", c, p1_gnt, dbg_state);
         end else if (c == 17 && (p1_gnt !== 1 || dbg_state !== 2'd0)) begin
            failures++;
            $display("FAIL timeout_expire got p1_gnt=%b st=%0d exp 1/0", p1_gnt, dbg_state);
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(0, 1, 32'h10, 3'b010, 0, 0, 0);
      tick();
      rst = 1;
      drive(0, 1, 32'h14, 3'b010, 1, 0, 0);
      drive(1, 1, 32'h18, 3'b010, 1, 0, 0);
      @(negedge clk);
      checks++;
      if ({p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid} !== 5'b00000) begin
         failures++;
         $display("FAIL rstmid_during got gnt/we/rv=%b exp 00000", {p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid});
      end
      tick();
      rst = 0;
      idle_inputs();
      @(negedge clk);
      checks++;
      if (p0_rvalid !== 0 || p1_rvalid !== 0) begin
         failures++;
         $display("FAIL rstmid_after got rv=%b%b exp 00", p0_rvalid, p1_rvalid);
      end
      tick();
   endtask

   function automatic bit ref_illegal(input logic [2:0] op, input logic [31:0] a);
      int sz;
      if (op == 3'b011 || op == 3'b110 || op == 3'b111) return 1;
      sz = (op[1:0] == 2'b10) ? 4 : (op[1:0] == 2'b01) ? 2 : 1;
      return (a % sz) != 0;
   endfunction

   task automatic test_random();
      int          owner, idle_cnt, favour, win, pp;
      bit          pv, perr, pwe;
      logic [31:0] paddr;
      logic        rq [2];
      logic        lk [2];
      logic        we [2];
      logic [2:0]  op [2];
      logic [31:0] ad [2];
      logic [31:0] wd [2];
      logic [1:0]  exp_gnt;
      logic [31:0] exp_addr, exp_din, exp_rd0, exp_rd1;
      logic [2:0]  exp_op;
      logic        exp_we;
      do_reset();
      owner = -1; idle_cnt = 0; favour = 0; pv = 0; pp = 0; perr = 0; pwe = 0; paddr = 0;
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         for (int p = 0; p < 2; p++) begin
            rq[p] = ($urandom_range(0, 9) < 6);
            ad[p] = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 1) == 1) ad[p][1:0] = 2'b00;
            op[p] = 3'($urandom_range(0, 7));
            we[p] = 1'($urandom_range(0, 1));
            lk[p] = ($urandom_range(0, 3) == 0);
            wd[p] = $urandom;
            drive(p, rq[p], ad[p], op[p], we[p], lk[p], wd[p]);
         end
         win = -1;
         if (!rst) begin
            if (rq[0] && rq[1] && owner == -1) win = favour;
            else if (rq[0] && owner != 1) win = 0;
            else if (rq[1] && owner != 0) win = 1;
         end
         exp_gnt  = (win == 0) ? 2'b10 : (win == 1) ? 2'b01 : 2'b00;
         exp_addr = (win >= 0) ? ad[win] : 32'd0;
         exp_din  = (win >= 0) ? wd[win] : 32'd0;
         exp_op   = (win >= 0) ? op[win] : 3'b010;
         exp_we   = (win >= 0) ? (we[win] && !ref_illegal(op[win], ad[win])) : 1'b0;
         exp_rd0  = (pv && pp == 0 && !perr && !pwe) ? mem_fn(paddr) : 32'd0;
         exp_rd1  = (pv && pp == 1 && !perr && !pwe) ? mem_fn(paddr) : 32'd0;
         @(negedge clk);
         checks++;
         if ({p0_gnt, p1_gnt} !== exp_gnt || mem_we !== exp_we || mem_addr !== exp_addr ||
             mem_datain !== exp_din || mem_memop !== exp_op) begin
            failures++;
            $display("FAIL rand_issue[%0d] got gnt=%b we=%b addr=%h din=%h op=%b exp gnt=%b we=%b addr=%h din=%h op=%b",
                     n, {p0_gnt, p1_gnt}, mem_we, mem_addr, mem_datain, mem_memop,
                     exp_gnt, exp_we, exp_addr, exp_din, exp_op);
         end
         checks++;
         if (p0_rvalid !== (pv && !rst && pp == 0) || p1_rvalid !== (pv && !rst && pp == 1) ||
             p0_err !== (pv && !rst && pp == 0 && perr) || p1_err !== (pv && !rst && pp == 1 && perr) ||
             p0_rdata !== (rst ? 32'd0 : exp_rd0) || p1_rdata !== (rst ? 32'd0 : exp_rd1)) begin
            failures++;
            $display("FAIL rand_done[%0d] got rv=%b%b err=%b%b rd0=%h rd1=%h exp valid=%0d port=%0d err=%0d rd0=%h rd1=%h",
                     n, p0_rvalid, p1_rvalid, p0_err, p1_err, p0_rdata, p1_rdata,
                     pv && !rst, pp, perr, exp_rd0, exp_rd1);
         end
         if (rst) begin
            owner = -1; idle_cnt = 0; favour = 0; pv = 0;
         end else if (win >= 0) begin
            pv = 1; pp = win; perr = ref_illegal(op[win], ad[win]); pwe = we[win]; paddr = ad[win];
            owner = lk[win] ? win : -1;
            idle_cnt = 0;
`ifdef DMEM_ARB_RR_EN
            favour = 1 - win;
`endif
         end else begin
            pv = 0;
            if (owner != -1) begin
               idle_cnt++;
               if (idle_cnt == 15) begin
                  owner = -1;
                  idle_cnt = 0;
               end
            end
         end
         tick();
      end
      rst = 0;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      tick();
      test_reset();
      test_contention();
      test_lock();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
